pipe_fifo: RTL

- Parametrised successor to the fixed two-entry valid/ready pipe stage.
- A DEPTH-entry circular buffer between two valid/ready interfaces, adding occupancy reporting, an almost-full flag, a synchronous flush and a high-water-mark register.
- Sits between producer and consumer datapaths wherever more than two beats of elasticity are needed.
- Outputs are driven from registers only; no combinational path from i_vld/i_rdy to o_rdy/o_vld.

---
 rtl/pipe_fifo.sv | 107 ++++++++++
 1 files changed

// File: rtl/pipe_fifo.sv
// pipe_fifo: DEPTH-entry circular-buffer FIFO between two valid/ready
// interfaces, with occupancy, almost-full, synchronous flush and a
// high-water-mark register. All outputs come from registered state
// (o_rdy additionally masks the synchronous flush input).
module pipe_fifo #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       i_reset_n,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_vld,
    output logic                       o_rdy,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_vld,
    input  logic                       i_rdy,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_afull,
    output logic [$clog2(DEPTH+1)-1:0] o_hwm
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Reject illegal configurations at elaboration time.
    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $fatal(1, "pipe_fifo: DEPTH must be a power of two and >= 2");
        end
        if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH)) begin : g_bad_thresh
            $fatal(1, "pipe_fifo: AFULL_THRESH must be in 1..DEPTH");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    hwm;

    logic [PW-1:0]    rd_ptr_next;
    logic [PW-1:0]    wr_ptr_next;
    logic [CW-1:0]    count_next;
    logic [CW-1:0]    hwm_next;
    logic             wr;
    logic             rd;

    assign o_vld   = (count != '0);
    assign o_rdy   = (count != CW'(DEPTH)) && !i_flush;
    assign o_data  = mem[rd_ptr];
    assign o_count = count;
    assign o_afull = (count >= CW'(AFULL_THRESH));
    assign o_hwm   = hwm;

    assign wr = i_vld && o_rdy;
    assign rd = o_vld && i_rdy;

    // Next pointer/count/high-water values; flush overrides everything.
    always_comb begin
        rd_ptr_next = rd_ptr;
        wr_ptr_next = wr_ptr;
        count_next  = count;
        if (i_flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (wr) begin
                wr_ptr_next = wr_ptr + PW'(1);
            end
            if (rd) begin
                rd_ptr_next = rd_ptr + PW'(1);
            end
            if (wr && !rd) begin
                count_next = count + CW'(1);
            end else if (rd && !wr) begin
                count_next = count - CW'(1);
            end
        end
        hwm_next = (count_next > hwm) ? count_next : hwm;
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            hwm    <= '0;
        end else begin
            rd_ptr <= rd_ptr_next;
            wr_ptr <= wr_ptr_next;
            count  <= count_next;
            hwm    <= hwm_next;
        end
    end

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= i_data;
        end
    end

endmodule
